// File: rtl/instr_queue_pkg.sv
// Shared constants and types for the instruction queue.
// Entries pair an instruction word with its fetch PC.
package instr_queue_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int ENTRY_W  = 64;
  localparam int INSTR_W  = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } entry_t;

  function automatic logic [1:0] clamp_deq(
    input logic [1:0] d
  );
    return (d == 2'd3) ? 2'd2 : d;
  endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Fetch/decode side bundle of the instruction queue.
// master = fetch/decode driver, slave = the queue.
interface instr_queue_if
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic        flush;
  logic        enq;
  logic [31:0] instrf;
  logic [31:0] instrf2;
  logic [31:0] pcf;
  logic [1:0]  deq;
  logic [31:0] instrd;
  logic [31:0] pcd;
  logic [31:0] instrd2;
  logic [31:0] pcd2;
  logic        validd;
  logic        validd2;
  logic        stallf;
  logic [CW-1:0] count;

  modport master (
    output flush, enq, instrf, instrf2,
    output pcf, deq,
    input  instrd, pcd, instrd2, pcd2,
    input  validd, validd2, stallf, count
  );

  modport slave (
    input  flush, enq, instrf, instrf2,
    input  pcf, deq,
    output instrd, pcd, instrd2, pcd2,
    output validd, validd2, stallf, count
  );

endinterface

// File: rtl/iq_storage.sv
// Entry array: two write ports (tail, tail+1) and two
// asynchronous read ports (head, head+1). Not reset.
module iq_storage
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [AW-1:0] waddr1_i,
  input  entry_t        wdata0_i,
  input  entry_t        wdata1_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output entry_t        rdata0_o,
  output entry_t        rdata1_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr0_i] <= wdata0_i;
      mem_q[waddr1_i] <= wdata1_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/instr_queue.sv
// Dual-issue instruction queue between fetch and decode.
// Pairs enter at tail, up to two leave from head per cycle.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  instr_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] STALL_LIM = CW'(DEPTH - 2);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          stall;
  logic          enq_acc;
  logic [1:0]    deq_req;
  logic [1:0]    deq_eff;
  logic          v0, v1;
  entry_t        wd0, wd1, rd0, rd1;

  assign stall   = count_q > STALL_LIM;
  assign enq_acc = bus.enq & ~stall & ~bus.flush;
  assign deq_req = clamp_deq(bus.deq);

  // Never pop more entries than are held.
  always_comb begin
    deq_eff = deq_req;
    unique case (1'b1)
      (count_q == '0):
        deq_eff = 2'd0;
      (count_q == CW'(1) && deq_req[1]):
        deq_eff = 2'd1;
      default: ;
    endcase
  end

  always_comb begin
    head_d  = head_q + AW'(deq_eff);
    tail_d  = tail_q + (enq_acc ? AW'(2) : '0);
    count_d = count_q
            + (enq_acc ? CW'(2) : '0)
            - CW'(deq_eff);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign wd0 = '{instr: bus.instrf,
                 pc:    bus.pcf};
  assign wd1 = '{instr: bus.instrf2,
                 pc:    bus.pcf + PC_INC};

  iq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk      (clk),
    .we_i     (enq_acc),
    .waddr0_i (tail_q),
    .waddr1_i (tail_q + AW'(1)),
    .wdata0_i (wd0),
    .wdata1_i (wd1),
    .raddr0_i (head_q),
    .raddr1_i (head_q + AW'(1)),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

  assign v0 = count_q != '0;
  assign v1 = count_q >= CW'(2);

  assign bus.validd  = v0;
  assign bus.validd2 = v1;
  assign bus.instrd  = v0 ? rd0.instr : '0;
  assign bus.pcd     = v0 ? rd0.pc    : '0;
  assign bus.instrd2 = v1 ? rd1.instr : '0;
  assign bus.pcd2    = v1 ? rd1.pc    : '0;
  assign bus.stallf  = stall;
  assign bus.count   = count_q;

endmodule
